// File: rtl/glb_start_irq_ctrl.sv
// rtl/glb_start_irq_ctrl.sv - GLB tile start pulse issue, interrupt collection and status tracking
module glb_start_irq_ctrl #(
    parameter int NUM_GLB_TILES = 16,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start_valid,
    input  logic [1:0]               start_kind,
    input  logic [NUM_GLB_TILES-1:0] start_tile_mask,
    output logic                     start_ack,
    output logic                     start_err,
    output logic [NUM_GLB_TILES-1:0] strm_start_pulse,
    output logic [NUM_GLB_TILES-1:0] pc_start_pulse,
    input  logic [NUM_GLB_TILES-1:0] strm_f2g_interrupt_pulse,
    input  logic [NUM_GLB_TILES-1:0] strm_g2f_interrupt_pulse,
    input  logic [NUM_GLB_TILES-1:0] pcfg_g2f_interrupt_pulse,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_cycles,
    input  logic                     irq_clr_valid,
    input  logic [2:0]               irq_clr_mask,
    output logic [NUM_GLB_TILES-1:0] busy_f2g,
    output logic [NUM_GLB_TILES-1:0] busy_g2f,
    output logic [NUM_GLB_TILES-1:0] busy_pcfg,
    output logic [2:0]               done_status,
    output logic [2:0]               timeout_status,
    output logic [2:0]               spurious_status,
    output logic                     interrupt
);

    // Per-kind state is packed with the kind as the outer index: 0=f2g, 1=g2f, 2=pcfg.
    logic [2:0][NUM_GLB_TILES-1:0] busy_q, busy_d;
    logic [2:0][TIMEOUT_WIDTH-1:0] wd_q, wd_d;
    logic [2:0]                    done_q, done_d;
    logic [2:0]                    timeout_q, timeout_d;
    logic [2:0]                    spur_q, spur_d;
    logic                          interrupt_q, interrupt_d;
    logic                          start_ack_q, start_ack_d;
    logic                          start_err_q, start_err_d;
    logic [NUM_GLB_TILES-1:0]      strm_pulse_q, strm_pulse_d;
    logic [NUM_GLB_TILES-1:0]      pc_pulse_q, pc_pulse_d;

    logic [2:0][NUM_GLB_TILES-1:0] irq_vec;
    logic [2:0][NUM_GLB_TILES-1:0] busy_after_irq;
    logic [2:0]                    acc_k;
    logic [2:0]                    done_set;
    logic [2:0]                    spur_set;
    logic [2:0]                    to_fire;
    logic [2:0]                    clr;
    logic                          accept;

    assign irq_vec[0] = strm_f2g_interrupt_pulse;
    assign irq_vec[1] = strm_g2f_interrupt_pulse;
    assign irq_vec[2] = pcfg_g2f_interrupt_pulse;

    // Next-state: interrupts retire busy bits first, accept check looks at pre-update busy,
    // watchdog expiry drops whatever is still outstanding, then new starts are merged in.
    always_comb begin
        busy_after_irq = '0;
        acc_k          = '0;
        done_set       = '0;
        spur_set       = '0;
        to_fire        = '0;
        busy_d         = busy_q;
        wd_d           = wd_q;
        clr            = irq_clr_valid ? irq_clr_mask : 3'b000;
        for (int k = 0; k < 3; k++) begin
            busy_after_irq[k] = busy_q[k] & ~irq_vec[k];
            spur_set[k]       = |(irq_vec[k] & ~busy_q[k]);
            done_set[k]       = (busy_q[k] != '0) && (busy_after_irq[k] == '0);
            to_fire[k]        = (timeout_cycles != '0) && (busy_after_irq[k] != '0) &&
                                (wd_q[k] == timeout_cycles);
            acc_k[k]          = start_valid && (start_kind == 2'(k)) &&
                                (start_tile_mask != '0) &&
                                ((start_tile_mask & busy_q[k]) == '0);
            busy_d[k]         = (to_fire[k] ? '0 : busy_after_irq[k]) |
                                (acc_k[k] ? start_tile_mask : '0);
            if (acc_k[k] || to_fire[k] || (busy_after_irq[k] == '0)) begin
                wd_d[k] = '0;
            end else begin
                wd_d[k] = wd_q[k] + 1'b1;
            end
        end
        accept       = |acc_k;
        start_ack_d  = accept;
        start_err_d  = start_valid && !accept;
        strm_pulse_d = (acc_k[0] || acc_k[1]) ? start_tile_mask : '0;
        pc_pulse_d   = acc_k[2] ? start_tile_mask : '0;
        // A set event in the same cycle as a clear wins.
        done_d       = (done_q & ~clr) | done_set;
        timeout_d    = (timeout_q & ~clr) | to_fire;
        spur_d       = (spur_q & ~clr) | spur_set;
        interrupt_d  = |{done_q, timeout_q, spur_q};
    end

    // State and registered outputs; reset abandons outstanding tiles without raising status.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q       <= '0;
            wd_q         <= '0;
            done_q       <= '0;
            timeout_q    <= '0;
            spur_q       <= '0;
            interrupt_q  <= 1'b0;
            start_ack_q  <= 1'b0;
            start_err_q  <= 1'b0;
            strm_pulse_q <= '0;
            pc_pulse_q   <= '0;
        end else begin
            busy_q       <= busy_d;
            wd_q         <= wd_d;
            done_q       <= done_d;
            timeout_q    <= timeout_d;
            spur_q       <= spur_d;
            interrupt_q  <= interrupt_d;
            start_ack_q  <= start_ack_d;
            start_err_q  <= start_err_d;
            strm_pulse_q <= strm_pulse_d;
            pc_pulse_q   <= pc_pulse_d;
        end
    end

    assign start_ack        = start_ack_q;
    assign start_err        = start_err_q;
    assign strm_start_pulse = strm_pulse_q;
    assign pc_start_pulse   = pc_pulse_q;
    assign busy_f2g         = busy_q[0];
    assign busy_g2f         = busy_q[1];
    assign busy_pcfg        = busy_q[2];
    assign done_status      = done_q;
    assign timeout_status   = timeout_q;
    assign spurious_status  = spur_q;
    assign interrupt        = interrupt_q;

endmodule

// File: tb/tb_glb_start_irq_ctrl.sv
// tb/tb_glb_start_irq_ctrl.sv - scoreboard bench for glb_start_irq_ctrl
module tb_glb_start_irq_ctrl;

    localparam int N  = 16;
    localparam int TW = 24;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start_valid = 1'b0;
    logic [1:0]    start_kind = '0;
    logic [N-1:0]  start_tile_mask = '0;
    logic          start_ack, start_err;
    logic [N-1:0]  strm_start_pulse, pc_start_pulse;
    logic [N-1:0]  f2g_irq = '0, g2f_irq = '0, pcfg_irq = '0;
    logic [TW-1:0] timeout_cycles = '0;
    logic          irq_clr_valid = 1'b0;
    logic [2:0]    irq_clr_mask = '0;
    logic [N-1:0]  busy_f2g, busy_g2f, busy_pcfg;
    logic [2:0]    done_status, timeout_status, spurious_status;
    logic          interrupt;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic         ack;
        logic         err;
        logic [N-1:0] strm;
        logic [N-1:0] pc;
    } resp_t;

    resp_t exp_q[$];

    glb_start_irq_ctrl #(.NUM_GLB_TILES(N), .TIMEOUT_WIDTH(TW)) dut (
        .clk(clk), .reset_n(reset_n),
        .start_valid(start_valid), .start_kind(start_kind), .start_tile_mask(start_tile_mask),
        .start_ack(start_ack), .start_err(start_err),
        .strm_start_pulse(strm_start_pulse), .pc_start_pulse(pc_start_pulse),
        .strm_f2g_interrupt_pulse(f2g_irq), .strm_g2f_interrupt_pulse(g2f_irq),
        .pcfg_g2f_interrupt_pulse(pcfg_irq),
        .timeout_cycles(timeout_cycles),
        .irq_clr_valid(irq_clr_valid), .irq_clr_mask(irq_clr_mask),
        .busy_f2g(busy_f2g), .busy_g2f(busy_g2f), .busy_pcfg(busy_pcfg),
        .done_status(done_status), .timeout_status(timeout_status),
        .spurious_status(spurious_status), .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    // Monitor: every response strobe pops one expectation; pulses outside a strobe are faults.
    always @(negedge clk) begin
        resp_t act, exp;
        act = '{ack: start_ack, err: start_err, strm: strm_start_pulse, pc: pc_start_pulse};
        if (start_ack || start_err) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected got ack=%0b err=%0b strm=%h pc=%h, required none",
                         act.ack, act.err, act.strm, act.pc);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL resp got ack=%0b err=%0b strm=%h pc=%h, required ack=%0b err=%0b strm=%h pc=%h",
                             act.ack, act.err, act.strm, act.pc, exp.ack, exp.err, exp.strm, exp.pc);
                end
            end
        end else if ((strm_start_pulse | pc_start_pulse) != '0) begin
            checks++;
            errors++;
            $display("FAIL stray_pulse got strm=%h pc=%h, required 0", strm_start_pulse, pc_start_pulse);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h, required %h", name, act, exp);
        end
    endtask

    // Issue one start request; expected response goes to the scoreboard.
    task automatic do_start(input logic [1:0] kind, input logic [N-1:0] mask, input logic exp_ack);
        resp_t e;
        e.ack  = exp_ack;
        e.err  = !exp_ack;
        e.strm = (exp_ack && kind < 2) ? mask : '0;
        e.pc   = (exp_ack && kind == 2) ? mask : '0;
        exp_q.push_back(e);
        start_valid     = 1'b1;
        start_kind      = kind;
        start_tile_mask = mask;
        tick();
        start_valid     = 1'b0;
        start_tile_mask = '0;
    endtask

    task automatic clear(input logic [2:0] m);
        irq_clr_valid = 1'b1;
        irq_clr_mask  = m;
        tick();
        irq_clr_valid = 1'b0;
        irq_clr_mask  = '0;
    endtask

    initial begin
        // Reset state
        #3;
        chk("rst_busy", {busy_f2g, busy_g2f}, 32'h0);
        chk("rst_status", {23'h0, done_status, timeout_status, spurious_status}, 32'h0);
        chk("rst_irq", {31'h0, interrupt}, 32'h0);
        tick();
        reset_n = 1'b1;
        repeat (2) tick();

        // f2g start and two-step completion
        do_start(2'd0, 16'h0005, 1'b1);
        chk("f2g_busy_start", {16'h0, busy_f2g}, 32'h0005);
        repeat (8) tick();
        f2g_irq = 16'h0001; tick(); f2g_irq = '0;
        chk("f2g_busy_half", {16'h0, busy_f2g}, 32'h0004);
        chk("f2g_done_early", {29'h0, done_status}, 32'h0);
        repeat (4) tick();
        f2g_irq = 16'h0004; tick(); f2g_irq = '0;
        chk("f2g_busy_empty", {16'h0, busy_f2g}, 32'h0);
        chk("f2g_done", {29'h0, done_status}, 32'h1);
        chk("irq_lag", {31'h0, interrupt}, 32'h0);
        tick();
        chk("irq_high", {31'h0, interrupt}, 32'h1);
        clear(3'b001);
        chk("done_cleared", {29'h0, done_status}, 32'h0);
        tick();
        chk("irq_low", {31'h0, interrupt}, 32'h0);

        // pcfg starts, rejects, same-cycle interrupt and start
        do_start(2'd2, 16'h0002, 1'b1);
        do_start(2'd2, 16'h0002, 1'b0);
        do_start(2'd3, 16'h0001, 1'b0);
        do_start(2'd0, 16'h0000, 1'b0);
        do_start(2'd2, 16'h0001, 1'b1);
        chk("pcfg_busy2", {16'h0, busy_pcfg}, 32'h0003);
        pcfg_irq = 16'h0002;
        do_start(2'd2, 16'h0002, 1'b0);
        pcfg_irq = '0;
        chk("pcfg_busy_retire", {16'h0, busy_pcfg}, 32'h0001);
        pcfg_irq = 16'h0001;
        do_start(2'd2, 16'h0004, 1'b1);
        pcfg_irq = '0;
        chk("pcfg_busy_swap", {16'h0, busy_pcfg}, 32'h0004);
        chk("pcfg_done_swap", {29'h0, done_status}, 32'h4);
        pcfg_irq = 16'h0004; tick(); pcfg_irq = '0;
        clear(3'b111);
        chk("pcfg_clear", {29'h0, done_status}, 32'h0);
        tick();

        // Spurious g2f interrupt
        g2f_irq = 16'h0008; tick(); g2f_irq = '0;
        chk("spur_status", {29'h0, spurious_status}, 32'h2);
        chk("spur_busy", {16'h0, busy_g2f}, 32'h0);
        tick();
        chk("spur_irq", {31'h0, interrupt}, 32'h1);
        clear(3'b010);
        chk("spur_clear", {29'h0, spurious_status}, 32'h0);
        tick();

        // Same tile busy in two kinds; clear loses to same-cycle completion
        do_start(2'd0, 16'h0001, 1'b1);
        do_start(2'd1, 16'h0001, 1'b1);
        chk("dual_busy", {busy_f2g, busy_g2f}, 32'h0001_0001);
        f2g_irq = 16'h0001;
        clear(3'b001);
        f2g_irq = '0;
        chk("clr_vs_set", {29'h0, done_status}, 32'h1);
        g2f_irq = 16'h0001; tick(); g2f_irq = '0;
        clear(3'b111);
        chk("dual_clear", {29'h0, done_status}, 32'h0);

        // Watchdog timeout on g2f
        timeout_cycles = 24'd100;
        do_start(2'd1, 16'h0001, 1'b1);
        repeat (100) tick();
        chk("to_before", {16'h0, busy_g2f}, 32'h0001);
        chk("to_before_st", {29'h0, timeout_status}, 32'h0);
        tick();
        chk("to_busy", {16'h0, busy_g2f}, 32'h0);
        chk("to_status", {29'h0, timeout_status}, 32'h2);
        chk("to_no_done", {29'h0, done_status}, 32'h0);
        clear(3'b111);
        timeout_cycles = '0;
        tick();

        // Asynchronous reset mid-operation
        do_start(2'd0, 16'h0003, 1'b1);
        repeat (2) tick();
        chk("pre_rst_busy", {16'h0, busy_f2g}, 32'h0003);
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", {16'h0, busy_f2g}, 32'h0);
        tick();
        reset_n = 1'b1;
        repeat (5) tick();
        chk("post_rst_status", {23'h0, done_status, timeout_status, spurious_status}, 32'h0);
        chk("post_rst_irq", {31'h0, interrupt}, 32'h0);

        chk("sb_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1);
    end

endmodule
